// File: rtl/c3aibadapt_txclk_gate_ctl.sv
// ---------------------------------------------------------------------------
// c3aibadapt_txclk_gate_ctl
// Multi-channel TX clock-gating controller. Each channel owns a small FSM
// (OFF / WAKE / ON / DRAIN) that decides when its gate opens, when the
// requester is acknowledged, and how long the clock keeps running after the
// request drops. The gate itself is a low-transparent latch feeding an AND,
// so gated clocks never glitch or produce truncated pulses. A test enable
// forces every gate open without disturbing the FSMs.
// ---------------------------------------------------------------------------
module c3aibadapt_txclk_gate_ctl #(
    parameter int NUM_CH   = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 3,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              te,
    input  logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] q,
    output logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] gate_on,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             en_lat;

        // State and countdown register for this channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_OFF;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // Next-state logic: wake delay, idle hysteresis, direct DRAIN->ON re-entry.
        // NOTE: combinational blocks use blocking '=' with every output defaulted
        // first; sequential blocks use '<=' so all flops update together.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            unique case (state)
                ST_OFF: begin
                    if (en[i]) begin
                        if (WAKE_CYC == 0) begin
                            state_nxt = ST_ON;
                        end else begin
                            state_nxt = ST_WAKE;
                            cnt_nxt   = WAKE_LD;
                        end
                    end
                end
                ST_WAKE: begin
                    if (!en[i]) begin
                        if (IDLE_CYC == 0) begin
                            state_nxt = ST_OFF;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = ST_DRAIN;
                            cnt_nxt   = IDLE_LD;
                        end
                    end else if (cnt == CNT_ONE) begin
                        state_nxt = ST_ON;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ST_ON: begin
                    if (!en[i]) begin
                        if (IDLE_CYC == 0) begin
                            state_nxt = ST_OFF;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = ST_DRAIN;
                            cnt_nxt   = IDLE_LD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (en[i]) begin
                        // Clock never stopped, so no fresh wake delay is needed.
                        state_nxt = ST_ON;
                        cnt_nxt   = '0;
                    end else if (cnt <= CNT_ONE) begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign gate_on[i] = (state != ST_OFF);
        assign ack[i]     = (state == ST_ON);

        // Gate enable latch: transparent while clk is low, cleared by reset.
        // NOTE: this latch is deliberate; always_latch documents it, whereas an
        // incomplete always_comb would infer the same storage by accident.
        always_latch begin
            if (!rst_n) begin
                en_lat <= te;
            end else if (!clk) begin
                en_lat <= gate_on[i] | te;
            end
        end

        assign q[i] = clk & en_lat;
    end

    assign busy = |gate_on;

endmodule

// File: tb/tb_c3aibadapt_txclk_gate_ctl.sv
// ---------------------------------------------------------------------------
// Testbench for c3aibadapt_txclk_gate_ctl.
// The reference model describes each channel by edge arithmetic: the gate is
// open while a request was seen within the last IDLE_CYC edges, and ack holds
// while the request is present and either WAKE_CYC edges have passed since
// the gate opened or the request already dropped once during that opening.
// ---------------------------------------------------------------------------
module tb_c3aibadapt_txclk_gate_ctl;

    localparam int NUM_CH   = 4;
    localparam int WAKE_CYC = 2;
    localparam int IDLE_CYC = 3;
    localparam int CNT_W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              te  = 1'b0;
    logic [NUM_CH-1:0] en  = '0;
    logic [NUM_CH-1:0] q;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] gate_on;
    logic              busy;

    c3aibadapt_txclk_gate_ctl #(
        .NUM_CH  (NUM_CH),
        .WAKE_CYC(WAKE_CYC),
        .IDLE_CYC(IDLE_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .te     (te),
        .en     (en),
        .q      (q),
        .ack    (ack),
        .gate_on(gate_on),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        int   last_one;  // most recent edge with en sampled 1
        int   start;     // edge at which the current gate opening began
        logic gap;       // en was 0 at some edge of the current opening
        logic gon;
        logic ack;
    } ch_m_t;

    localparam ch_m_t M_RST = '{last_one: -1000, start: 0, gap: 1'b0, gon: 1'b0, ack: 1'b0};

    ch_m_t mdl [NUM_CH];
    int    edge_n;

    function automatic ch_m_t step_ch(input ch_m_t s, input logic e, input int k);
        ch_m_t r;
        r = s;
        if (e) r.last_one = k;
        r.gon = ((k - r.last_one) <= IDLE_CYC);
        if (r.gon && !s.gon) begin
            r.start = k;
            r.gap   = 1'b0;
        end
        r.ack = e && (((k - r.start) >= WAKE_CYC) || r.gap);
        if (!e) r.gap = 1'b1;
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] model_gon();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = mdl[i].gon;
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] model_ack();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = mdl[i].ack;
        return v;
    endfunction

    // Model advances on each sampled edge; edges while in reset do not count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n <= 0;
            for (int i = 0; i < NUM_CH; i++) mdl[i] <= M_RST;
        end else begin
            edge_n <= edge_n + 1;
            for (int i = 0; i < NUM_CH; i++) mdl[i] <= step_ch(mdl[i], en[i], edge_n + 1);
        end
    end

    // ---------------- compare processes ----------------
    logic [NUM_CH-1:0] exp_q = '0;
    int                ack_cnt [NUM_CH];
    int                pc      [NUM_CH];

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            ack_cnt[i] = 0;
            pc[i]      = 0;
        end
    end

    // Registered outputs checked mid-cycle; expected q for the next high phase
    // is what the latch sees at the end of this low phase.
    always @(negedge clk) begin
        check("gate_on", 32'(gate_on), 32'(model_gon()));
        check("ack", 32'(ack), 32'(model_ack()));
        check("busy", 32'(busy), 32'(|model_gon()));
        for (int i = 0; i < NUM_CH; i++) if (ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
        exp_q <= model_gon() | {NUM_CH{te}};
    end

    // Gated clocks checked early and late in the high phase (catches runts).
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("q_hi_early", 32'(q), 32'(exp_q));
            for (int i = 0; i < NUM_CH; i++) if (q[i]) pc[i] <= pc[i] + 1;
        end
        #3;
        if (rst_n) check("q_hi_late", 32'(q), 32'(exp_q));
    end

    always @(negedge clk) begin
        #1;
        check("q_lo", 32'(q), 32'd0);
    end

    // ---------------- directed stimulus ----------------
    // Returns 2 time units after edge n (inside the high phase).
    task automatic at_edge(input int n);
        int guard = 0;
        while (edge_n != n && guard < 2000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (edge_n != n) check("at_edge_timeout", 32'(edge_n), 32'(n));
    endtask

    int base [NUM_CH];
    int ab2;

    initial begin
        rst_n = 1'b0;
        #17;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_gate_on", 32'(gate_on), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        #5 rst_n = 1'b1;

        // ch0 wake-up
        at_edge(9);  en = 4'b0001;
        at_edge(10); #1;
        check("c0_gate_on_e10", 32'(gate_on), 32'h1);
        check("c0_ack_e10", 32'(ack), 32'h0);
        base[0] = pc[0];
        at_edge(11); #1;
        check("c0_ack_e11", 32'(ack), 32'h0);
        check("c0_first_pulse", 32'(pc[0] - base[0]), 32'd1);
        at_edge(12); #1;
        check("c0_ack_e12", 32'(ack), 32'h1);

        // ch0 drain
        at_edge(19); en = 4'b0000;
        at_edge(20); #1;
        check("c0_ack_drop", 32'(ack), 32'h0);
        check("c0_gate_hold", 32'(gate_on), 32'h1);
        base[0] = pc[0];
        at_edge(23); #1;
        check("c0_gate_off", 32'(gate_on), 32'h0);
        check("c0_busy_off", 32'(busy), 32'h0);
        at_edge(24); en = 4'b0010; #1;
        check("c0_drain_pulses", 32'(pc[0] - base[0]), 32'd3);
        check("c1_idle_pulses", 32'(pc[1]), 32'd0);
        check("c2_idle_pulses", 32'(pc[2]), 32'd0);
        check("c3_idle_pulses", 32'(pc[3]), 32'd0);

        // ch1 re-request during DRAIN
        at_edge(25); #1;
        base[1] = pc[1];
        at_edge(27); #1;
        check("c1_ack_on", 32'(ack), 32'h2);
        at_edge(29); en = 4'b0000;
        at_edge(30); #1;
        check("c1_ack_drop", 32'(ack), 32'h0);
        at_edge(31); en = 4'b0010;
        at_edge(32); #1;
        check("c1_ack_reentry", 32'(ack), 32'h2);
        at_edge(33); #1;
        check("c1_no_missing_pulse", 32'(pc[1] - base[1]), 32'd8);

        // ch2 aborts mid-WAKE
        at_edge(39); en = 4'b0110; #1;
        base[2] = pc[2];
        ab2     = ack_cnt[2];
        at_edge(40); en = 4'b0010;
        at_edge(46); #1;
        check("c2_abort_pulses", 32'(pc[2] - base[2]), 32'd4);
        check("c2_abort_gate", 32'(gate_on), 32'h2);
        check("c2_never_ack", 32'(ack_cnt[2] - ab2), 32'd0);
        at_edge(49); en = 4'b0000;
        at_edge(54); #1;
        check("all_idle_busy", 32'(busy), 32'h0);

        // test-enable override
        at_edge(56); te = 1'b1; #1;
        for (int i = 0; i < NUM_CH; i++) base[i] = pc[i];
        at_edge(60); te = 1'b0; #1;
        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("te_pulses_%0d", i), 32'(pc[i] - base[i]), 32'd4);
        check("te_ack", 32'(ack), 32'h0);
        check("te_gate_on", 32'(gate_on), 32'h0);
        at_edge(63); #1;
        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("te_stop_%0d", i), 32'(pc[i] - base[i]), 32'd4);

        // all channels on, then reset in the high phase
        at_edge(64); en = 4'b1111;
        at_edge(70); #1;
        check("all_ack", 32'(ack), 32'hF);
        rst_n = 1'b0;
        #1;
        check("midrst_q", 32'(q), 32'h0);
        check("midrst_ack", 32'(ack), 32'h0);
        check("midrst_gate_on", 32'(gate_on), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // en held high through release: request taken at the first edge
        at_edge(1); #1;
        check("rel_gate_on_e1", 32'(gate_on), 32'hF);
        at_edge(2); #1;
        check("rel_ack_e2", 32'(ack), 32'h0);
        at_edge(3); #1;
        check("rel_ack_e3", 32'(ack), 32'hF);
        at_edge(5); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
